pid_wb_sequencer: RTL and testbench

- Wishbone master that configures and runs one `pid` instance.
- On command, writes the four gain/setpoint registers (kp, ki, kd, sp).
- Then runs a sample loop: accepts process-value (pv) samples over a valid/ready handshake, writes each to the pid pv register, waits for the pid's u(n) valid pulse, and returns u(n) to the requester.
- Sits between the control-loop front end (ADC/sample source) and the pid block; it is the pid's only bus master.

---
 rtl/pid_wb_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_pid_wb_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_wb_sequencer.sv
// ============================================================================
//  pid_wb_sequencer
//  Wishbone master that loads kp/ki/kd/sp into a pid block, then feeds it
//  pv samples one at a time and returns each u(n) result.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pid_wb_sequencer #(
    parameter int unsigned             WB_NB     = 16,
    parameter int unsigned             ADR_WB_NB = 16,
    parameter logic [ADR_WB_NB-1:0]    KP_ADR    = 0,
    parameter logic [ADR_WB_NB-1:0]    KI_ADR    = 1,
    parameter logic [ADR_WB_NB-1:0]    KD_ADR    = 2,
    parameter logic [ADR_WB_NB-1:0]    SP_ADR    = 3,
    parameter logic [ADR_WB_NB-1:0]    PV_ADR    = 4,
    parameter int unsigned             TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_start,
    input  logic [WB_NB-1:0]     i_kp,
    input  logic [WB_NB-1:0]     i_ki,
    input  logic [WB_NB-1:0]     i_kd,
    input  logic [WB_NB-1:0]     i_sp,
    output logic                 o_cfg_done,
    input  logic                 i_pv_valid,
    output logic                 o_pv_ready,
    input  logic [WB_NB-1:0]     i_pv,
    output logic [31:0]          o_un,
    output logic                 o_un_valid,
    output logic                 o_busy,
    output logic                 o_err,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [ADR_WB_NB-1:0] o_wb_adr,
    output logic [WB_NB-1:0]     o_wb_data,
    input  logic                 i_wb_ack,
    input  logic [WB_NB-1:0]     i_wb_data,
    input  logic [31:0]          i_pid_un,
    input  logic                 i_pid_valid
);

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG_WR  = 3'd1,
        S_CFG_GAP = 3'd2,
        S_READY   = 3'd3,
        S_PV_WR   = 3'd4,
        S_WAIT_UN = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_idx;
    logic [15:0]            r_tmo;
    logic [WB_NB-1:0]       r_kp, r_ki, r_kd, r_sp;
    logic                   r_stb;
    logic                   r_cfg_done;
    logic                   r_pv_ready;
    logic                   r_un_valid;
    logic                   r_busy;
    logic                   r_err;
    logic [ADR_WB_NB-1:0]   r_adr;
    logic [WB_NB-1:0]       r_dat;
    logic [31:0]            r_un;

    logic                   w_tmo_hit;
    logic                   w_cfg_go;
    logic [1:0]             w_nxt_idx;
    logic [ADR_WB_NB-1:0]   w_nxt_adr;
    logic [WB_NB-1:0]       w_nxt_dat;
    logic                   w_unused;

    assign w_unused  = ^i_wb_data;
    assign w_tmo_hit = (r_tmo == c_tmo_last);
    assign w_cfg_go  = i_cfg_start &&
                       (r_state == S_IDLE || r_state == S_READY || r_state == S_ERR);
    assign w_nxt_idx = r_idx + 2'd1;

    always_comb begin
        w_nxt_adr = KP_ADR;
        w_nxt_dat = r_kp;
        case (w_nxt_idx)
            2'd1:    begin w_nxt_adr = KI_ADR; w_nxt_dat = r_ki; end
            2'd2:    begin w_nxt_adr = KD_ADR; w_nxt_dat = r_kd; end
            2'd3:    begin w_nxt_adr = SP_ADR; w_nxt_dat = r_sp; end
            default: begin w_nxt_adr = KP_ADR; w_nxt_dat = r_kp; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_tmo      <= 16'd0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_sp       <= '0;
            r_stb      <= 1'b0;
            r_cfg_done <= 1'b0;
            r_pv_ready <= 1'b0;
            r_un_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_un       <= '0;
        end else begin
            r_un_valid <= 1'b0;
            if (w_cfg_go) begin
                // (Re)start configuration; the first write is presented next cycle
                r_kp       <= i_kp;
                r_ki       <= i_ki;
                r_kd       <= i_kd;
                r_sp       <= i_sp;
                r_idx      <= 2'd0;
                r_cfg_done <= 1'b0;
                r_err      <= 1'b0;
                r_pv_ready <= 1'b0;
                r_stb      <= 1'b1;
                r_adr      <= KP_ADR;
                r_dat      <= i_kp;
                r_tmo      <= 16'd0;
                r_busy     <= 1'b1;
                r_state    <= S_CFG_WR;
            end else begin
                case (r_state)
                    S_CFG_WR: begin
                        if (i_wb_ack) begin
                            r_stb   <= 1'b0;
                            r_state <= S_CFG_GAP;
                        end else if (w_tmo_hit) begin
                            r_stb      <= 1'b0;
                            r_err      <= 1'b1;
                            r_cfg_done <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_ERR;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    S_CFG_GAP: begin
                        if (r_idx == 2'd3) begin
                            r_cfg_done <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_READY;
                        end else begin
                            r_idx   <= w_nxt_idx;
                            r_adr   <= w_nxt_adr;
                            r_dat   <= w_nxt_dat;
                            r_stb   <= 1'b1;
                            r_tmo   <= 16'd0;
                            r_state <= S_CFG_WR;
                        end
                    end
                    S_READY: begin
                        // Ready rises one cycle after entry so it trails o_un_valid
                        if (i_pv_valid && r_pv_ready) begin
                            r_pv_ready <= 1'b0;
                            r_adr      <= PV_ADR;
                            r_dat      <= i_pv;
                            r_stb      <= 1'b1;
                            r_tmo      <= 16'd0;
                            r_busy     <= 1'b1;
                            r_state    <= S_PV_WR;
                        end else begin
                            r_pv_ready <= 1'b1;
                        end
                    end
                    S_PV_WR: begin
                        if (i_wb_ack) begin
                            r_stb   <= 1'b0;
                            r_tmo   <= 16'd0;
                            r_state <= S_WAIT_UN;
                        end else if (w_tmo_hit) begin
                            r_stb      <= 1'b0;
                            r_err      <= 1'b1;
                            r_cfg_done <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_ERR;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    S_WAIT_UN: begin
                        if (i_pid_valid) begin
                            r_un       <= i_pid_un;
                            r_un_valid <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_READY;
                        end else if (w_tmo_hit) begin
                            r_err      <= 1'b1;
                            r_cfg_done <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_ERR;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_cfg_done = r_cfg_done;
    assign o_pv_ready = r_pv_ready;
    assign o_un       = r_un;
    assign o_un_valid = r_un_valid;
    assign o_busy     = r_busy;
    assign o_err      = r_err;
    assign o_wb_cyc   = r_stb;
    assign o_wb_stb   = r_stb;
    assign o_wb_we    = r_stb;
    assign o_wb_adr   = r_adr;
    assign o_wb_data  = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_pid_wb_sequencer.sv
// ============================================================================
//  tb_pid_wb_sequencer
//  Randomized self-checking bench with Wishbone slave and pid stand-in.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pid_wb_sequencer;

    localparam int TMO = 24;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_start;
    logic [15:0] i_kp, i_ki, i_kd, i_sp;
    logic        o_cfg_done;
    logic        i_pv_valid;
    logic        o_pv_ready;
    logic [15:0] i_pv;
    logic [31:0] o_un;
    logic        o_un_valid;
    logic        o_busy;
    logic        o_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [15:0] o_wb_adr;
    logic [15:0] o_wb_data;
    logic        i_wb_ack;
    logic [15:0] i_wb_data;
    logic [31:0] i_pid_un;
    logic        i_pid_valid;

    always #5 i_clk = ~i_clk;

    pid_wb_sequencer #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_start(i_cfg_start),
        .i_kp(i_kp), .i_ki(i_ki), .i_kd(i_kd), .i_sp(i_sp),
        .o_cfg_done(o_cfg_done), .i_pv_valid(i_pv_valid), .o_pv_ready(o_pv_ready),
        .i_pv(i_pv), .o_un(o_un), .o_un_valid(o_un_valid), .o_busy(o_busy),
        .o_err(o_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack),
        .i_wb_data(i_wb_data), .i_pid_un(i_pid_un), .i_pid_valid(i_pid_valid)
    );

    int n_pass = 0;
    int n_total = 0;

    // Observed bus writes and results, and the reference expectations
    logic [31:0] wr_q[$];
    logic [31:0] exp_wr[$];
    logic [31:0] un_q[$];
    int          gap_q[$];
    int          viol = 0;

    int ack_wait  = 0;
    int nack_adr  = -1;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_cfg(input logic [15:0] a, b, c, d);
        exp_wr.push_back({16'd0, a});
        exp_wr.push_back({16'd1, b});
        exp_wr.push_back({16'd2, c});
        exp_wr.push_back({16'd3, d});
    endtask

    // Wishbone slave: acks after ack_wait cycles of stb, never for nack_adr
    initial begin : slave
        int wcnt;
        wcnt = 0;
        i_wb_ack = 1'b0;
        forever begin
            tick();
            i_wb_ack = 1'b0;
            if (!i_rst && o_wb_stb && !(nack_adr >= 0 && int'(o_wb_adr) == nack_adr)) begin
                if (wcnt >= ack_wait) begin
                    i_wb_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Bus/handshake monitor
    initial begin : monitor
        logic        p_stb, p_ack, p_unv;
        logic [15:0] p_adr, p_dat;
        int          low_run;
        p_stb = 0; p_ack = 0; p_unv = 0; p_adr = 0; p_dat = 0; low_run = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                p_stb = 0; p_ack = 0; p_unv = 0; low_run = 0;
            end else begin
                if (o_wb_stb && !p_stb) gap_q.push_back(low_run);
                if (o_wb_stb && p_stb && (p_ack || o_wb_adr !== p_adr || o_wb_data !== p_dat)) viol++;
                if (o_wb_cyc !== o_wb_stb || (o_wb_stb && o_wb_we !== 1'b1)) viol++;
                if (o_pv_ready && o_busy) viol++;
                if (o_un_valid && p_unv) viol++;
                if (o_wb_stb && i_wb_ack) wr_q.push_back({o_wb_adr, o_wb_data});
                if (o_un_valid) un_q.push_back(o_un);
                low_run = o_wb_stb ? 0 : low_run + 1;
                p_stb = o_wb_stb; p_ack = i_wb_ack; p_unv = o_un_valid;
                p_adr = o_wb_adr; p_dat = o_wb_data;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Drive a configuration and count cycles until o_cfg_done rises
    task automatic run_config(input logic [15:0] a, b, c, d, input int aw,
                              output int cyc, output logic stb_first);
        ack_wait = aw;
        i_kp = a; i_ki = b; i_kd = c; i_sp = d;
        i_cfg_start = 1'b1;
        tick();
        i_cfg_start = 1'b0;
        stb_first = o_wb_stb;
        cyc = 0;
        while (!o_cfg_done && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    // Push one pv sample through and act as the pid with the given latency
    task automatic run_sample(input logic [15:0] pv_v, input int aw, input int lat,
                              input logic [31:0] un_v, input bit poke_start,
                              output bit ok, output logic unv, output logic rdy_at_unv,
                              output logic rdy_next);
        int n0, k;
        ok = 1; unv = 0; rdy_at_unv = 1; rdy_next = 0;
        k = 0;
        while (!o_pv_ready && k < 60) begin tick(); k++; end
        if (!o_pv_ready) begin ok = 0; return; end
        ack_wait = aw;
        i_pv = pv_v;
        i_pv_valid = 1'b1;
        n0 = wr_q.size();
        tick();
        i_pv_valid = 1'b0;
        if (poke_start) begin
            i_cfg_start = 1'b1;
            tick();
            i_cfg_start = 1'b0;
        end
        k = 0;
        while (wr_q.size() == n0 && k < 60) begin tick(); k++; end
        if (wr_q.size() == n0) begin ok = 0; return; end
        repeat (lat) tick();
        i_pid_un = un_v;
        i_pid_valid = 1'b1;
        tick();
        i_pid_valid = 1'b0;
        unv = o_un_valid;
        rdy_at_unv = o_pv_ready;
        tick();
        rdy_next = o_pv_ready;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_cfg_start = 0; i_pv_valid = 0; i_pid_valid = 0;
        i_kp = 0; i_ki = 0; i_kd = 0; i_sp = 0; i_pv = 0; i_pid_un = 0; i_wb_data = 0;
        repeat (3) tick();
        n_total++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_cfg_done, o_pv_ready,
             o_un, o_un_valid, o_busy, o_err} !== '0)
            $display("FAIL reset_outputs: got stb=%b adr=%h un=%h busy=%b err=%b, required all 0",
                     o_wb_stb, o_wb_adr, o_un, o_busy, o_err);
        else n_pass++;
        i_rst = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({o_pv_ready, o_busy, o_wb_stb} !== 3'b000)
            $display("FAIL idle_quiet: got ready/busy/stb=%b, required 000", {o_pv_ready, o_busy, o_wb_stb});
        else n_pass++;
    endtask

    task automatic check_writes(input string name);
        int bad;
        bad = (wr_q.size() != exp_wr.size()) ? 1 : 0;
        foreach (exp_wr[i]) if (i < wr_q.size() && wr_q[i] !== exp_wr[i]) bad = 1;
        n_total++;
        if (bad != 0)
            $display("FAIL %s: got %0d writes (first %h), required %0d (first %h)", name,
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'h0,
                     exp_wr.size(), (exp_wr.size() > 0) ? exp_wr[0] : 32'h0);
        else n_pass++;
        wr_q.delete();
        exp_wr.delete();
    endtask

    task automatic test_config(input logic [15:0] a, b, c, d, input int aw);
        int cyc, bad;
        logic s1;
        gap_q.delete();
        push_cfg(a, b, c, d);
        run_config(a, b, c, d, aw, cyc, s1);
        n_total++;
        if (s1 !== 1'b1) $display("FAIL cfg_stb_first: got %b, required 1", s1); else n_pass++;
        n_total++;
        if (cyc != 4 * (aw + 2))
            $display("FAIL cfg_latency: got %0d cycles, required %0d", cyc, 4 * (aw + 2));
        else n_pass++;
        n_total++;
        if (o_pv_ready !== 1'b0) $display("FAIL cfg_ready_early: got %b, required 0", o_pv_ready); else n_pass++;
        tick();
        n_total++;
        if (o_pv_ready !== 1'b1 || o_cfg_done !== 1'b1)
            $display("FAIL cfg_ready: got ready=%b done=%b, required 1 1", o_pv_ready, o_cfg_done);
        else n_pass++;
        bad = (gap_q.size() != 4) ? 1 : 0;
        for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 1) bad = 1;
        n_total++;
        if (bad != 0) $display("FAIL cfg_gaps: got %0d stb pulses / bad gap, required 4 with 1-cycle gaps", gap_q.size());
        else n_pass++;
        check_writes("cfg_writes");
    endtask

    task automatic test_sample(input logic [15:0] pv_v, input int aw, input int lat, input logic [31:0] un_v);
        bit ok;
        logic unv, r0, r1;
        int u0;
        u0 = un_q.size();
        exp_wr.push_back({16'd4, pv_v});
        run_sample(pv_v, aw, lat, un_v, 1'b0, ok, unv, r0, r1);
        n_total++;
        if (!ok || unv !== 1'b1 || o_un !== un_v)
            $display("FAIL sample_un: ok=%0d un_valid=%b got %h, required %h", ok, unv, o_un, un_v);
        else n_pass++;
        n_total++;
        if (r0 !== 1'b0 || r1 !== 1'b1 || un_q.size() != u0 + 1)
            $display("FAIL sample_ready: got ready %b then %b, pulses %0d, required 0 then 1, 1 pulse",
                     r0, r1, un_q.size() - u0);
        else n_pass++;
        check_writes("sample_write");
    endtask

    task automatic test_random_samples();
        for (int n = 0; n < 8; n++)
            test_sample(16'($urandom), $urandom_range(0, 4), $urandom_range(1, 15), $urandom);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa, pb;
        logic [31:0] ua, ub;
        int n0, u0, k, at2;
        pa = 16'($urandom); pb = 16'($urandom); ua = $urandom; ub = $urandom;
        k = 0;
        while (!o_pv_ready && k < 60) begin tick(); k++; end
        n0 = wr_q.size(); u0 = un_q.size();
        ack_wait = 2;
        i_pv = pa; i_pv_valid = 1'b1;
        tick();
        i_pv = pb;
        k = 0;
        while (wr_q.size() < n0 + 1 && k < 60) begin tick(); k++; end
        repeat (5) tick();
        i_pid_un = ua; i_pid_valid = 1'b1; tick(); i_pid_valid = 1'b0;
        k = 0;
        while (wr_q.size() < n0 + 2 && k < 60) begin tick(); k++; end
        at2 = un_q.size() - u0;
        i_pv_valid = 1'b0;
        repeat (7) tick();
        i_pid_un = ub; i_pid_valid = 1'b1; tick(); i_pid_valid = 1'b0;
        repeat (4) tick();
        n_total++;
        if (at2 != 1) $display("FAIL b2b_order: got %0d results before 2nd write, required 1", at2); else n_pass++;
        n_total++;
        if (un_q.size() != u0 + 2 || un_q[u0] !== ua || un_q[u0 + 1] !== ub)
            $display("FAIL b2b_results: got %0d results, required 2 (%h,%h)", un_q.size() - u0, ua, ub);
        else n_pass++;
        exp_wr.push_back({16'd4, pa});
        exp_wr.push_back({16'd4, pb});
        check_writes("b2b_writes");
    endtask

    task automatic test_timeout();
        int k, hi, cyc;
        logic s1;
        logic [15:0] v[4];
        for (int i = 0; i < 4; i++) v[i] = 16'($urandom);
        nack_adr = 2;
        ack_wait = 0;
        i_kp = v[0]; i_ki = v[1]; i_kd = v[2]; i_sp = v[3];
        i_cfg_start = 1'b1; tick(); i_cfg_start = 1'b0;
        k = 0;
        while (!(o_wb_stb && o_wb_adr == 16'd2) && k < 60) begin tick(); k++; end
        hi = 0;
        while (o_wb_stb && hi < 200) begin tick(); hi++; end
        n_total++;
        if (hi != TMO) $display("FAIL tmo_stb_len: got %0d cycles, required %0d", hi, TMO); else n_pass++;
        n_total++;
        if ({o_err, o_cfg_done, o_busy} !== 3'b100)
            $display("FAIL tmo_flags: got err/done/busy=%b, required 100", {o_err, o_cfg_done, o_busy});
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if ({o_err, o_pv_ready, o_wb_stb} !== 3'b100)
            $display("FAIL err_hold: got err/ready/stb=%b, required 100", {o_err, o_pv_ready, o_wb_stb});
        else n_pass++;
        exp_wr.push_back({16'd0, v[0]});
        exp_wr.push_back({16'd1, v[1]});
        check_writes("tmo_writes");
        nack_adr = -1;
        push_cfg(v[3], v[2], v[1], v[0]);
        run_config(v[3], v[2], v[1], v[0], 1, cyc, s1);
        n_total++;
        if (o_err !== 1'b0 || cyc != 12)
            $display("FAIL err_recover: got err=%b after %0d cycles, required 0 after 12", o_err, cyc);
        else n_pass++;
        check_writes("recover_writes");
    endtask

    task automatic test_reconfig_stray();
        logic [31:0] un0;
        int u0, cyc;
        logic s1, unv, r0, r1;
        bit ok;
        logic [15:0] pv_v;
        repeat (2) tick();
        un0 = o_un; u0 = un_q.size();
        i_pid_un = ~un0; i_pid_valid = 1'b1; tick(); i_pid_valid = 1'b0;
        repeat (2) tick();
        n_total++;
        if (o_un !== un0 || un_q.size() != u0)
            $display("FAIL stray_pid_valid: got un=%h pulses=%0d, required %h and 0", o_un, un_q.size() - u0, un0);
        else n_pass++;
        push_cfg(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        run_config(16'h1111, 16'h2222, 16'h3333, 16'h4444, 3, cyc, s1);
        n_total++;
        if (cyc != 20) $display("FAIL reconfig_done_low: got %0d cycles, required 20", cyc); else n_pass++;
        check_writes("reconfig_writes");
        pv_v = 16'($urandom);
        exp_wr.push_back({16'd4, pv_v});
        run_sample(pv_v, 4, 6, 32'h0BAD_F00D, 1'b1, ok, unv, r0, r1);
        n_total++;
        if (!ok || unv !== 1'b1 || o_un !== 32'h0BAD_F00D || o_cfg_done !== 1'b1)
            $display("FAIL start_in_pvwr: ok=%0d un=%h done=%b, required un 0badf00d done 1", ok, o_un, o_cfg_done);
        else n_pass++;
        check_writes("start_in_pvwr_writes");
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic s1;
        nack_adr = 0;
        i_kp = 16'hAAAA; i_ki = 16'hBBBB; i_kd = 16'hCCCC; i_sp = 16'hDDDD;
        i_cfg_start = 1'b1; tick(); i_cfg_start = 1'b0;
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        n_total++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_cfg_done, o_pv_ready,
             o_un, o_un_valid, o_busy, o_err} !== '0)
            $display("FAIL reset_mid: got stb=%b busy=%b done=%b un=%h, required all 0",
                     o_wb_stb, o_busy, o_cfg_done, o_un);
        else n_pass++;
        i_rst = 1'b0;
        nack_adr = -1;
        wr_q.delete();
        tick();
        push_cfg(16'h0010, 16'h0002, 16'h0001, 16'h0100);
        run_config(16'h0010, 16'h0002, 16'h0001, 16'h0100, 0, cyc, s1);
        n_total++;
        if (cyc != 8) $display("FAIL reset_mid_restart: got %0d cycles, required 8", cyc); else n_pass++;
        check_writes("reset_mid_writes");
    endtask

    initial begin
        test_reset();
        test_config(16'h0010, 16'h0002, 16'h0001, 16'h0100, 0);
        test_sample(16'h00F0, 3, 20, 32'h0000_1234);
        test_config(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 5));
        test_random_samples();
        test_back_to_back();
        test_timeout();
        test_reconfig_stray();
        test_reset_mid();
        n_total++;
        if (viol != 0) $display("FAIL protocol: got %0d violations, required 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
